// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, funct codes, ALU operations and observed register indices
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
    localparam logic [4:0] REG_T1 = 5'd9;
    localparam logic [4:0] REG_T2 = 5'd10;
    localparam logic [4:0] REG_T3 = 5'd11;
    localparam logic [4:0] REG_T4 = 5'd12;
    localparam logic [5:0] TEST_MEM_ADR = 6'd11;
endpackage

// File: rtl/mips_alu.sv
// mips_alu: 32-bit wrap-around ALU with signed set-less-than and zero flag
module mips_alu
    import mips_pkg::*;
(
    input  logic signed [31:0] a,
    input  logic signed [31:0] b,
    input  alu_op_t            op,
    output logic signed [31:0] result,
    output logic               zero
);
    // select the operation; add is the fallback for address and addi arithmetic
    always_comb begin
        result = op == ALU_SUB ? a - b :
                 op == ALU_AND ? a & b :
                 op == ALU_OR  ? a | b :
                 op == ALU_SLT ? {31'd0, a < b} :
                 a + b;
    end
    assign zero = result == '0;
endmodule

// File: rtl/shell.sv
// shell: single-cycle MIPS-subset core with loadable instruction memory
module shell
    import mips_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64
) (
    input  logic               clk,
    input  logic               res,
    input  logic               instr_en,
    input  logic [31:0]        mem_adr,
    input  logic [31:0]        mem_in,
    output logic signed [31:0] test_mem,
    output logic signed [31:0] t1,
    output logic signed [31:0] t2,
    output logic signed [31:0] t3,
    output logic signed [31:0] t4
);
    logic [31:0]        imem [IMEM_DEPTH];
    logic signed [31:0] rf [32];
    logic signed [31:0] dmem [DMEM_DEPTH];
    logic [5:0]         pc, pc_next;
    logic [31:0]        instr;
    logic [5:0]         opcode, funct;
    logic [4:0]         rs, rt, rd, wr_idx;
    logic signed [31:0] imm_ext, rs_val, rt_val, alu_b, alu_res, wb;
    logic               reg_we, mem_we, mem_to_reg, use_imm, zero;
    alu_op_t            alu_op;
    logic [5:0]         dadr;
    logic               unused_bits;

    assign instr   = imem[pc];
    assign opcode  = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign funct   = instr[5:0];
    assign imm_ext = {{16{instr[15]}}, instr[15:0]};
    assign rs_val  = rf[rs];
    assign rt_val  = rf[rt];
    assign alu_b   = use_imm ? imm_ext : rt_val;
    assign dadr    = alu_res[5:0];
    assign wb      = mem_to_reg ? dmem[dadr] : alu_res;
    assign unused_bits = ^{mem_adr[31:6], instr[10:6]};

    mips_alu u_alu (
        .a      (rs_val),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_res),
        .zero   (zero)
    );

    // decode: anything not recognised leaves every write disabled and acts as a NOP
    always_comb begin
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        mem_to_reg = 1'b0;
        use_imm    = 1'b0;
        wr_idx     = rd;
        alu_op     = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                reg_we = funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                         funct == FN_OR  || funct == FN_SLT;
                alu_op = funct == FN_SUB ? ALU_SUB :
                         funct == FN_AND ? ALU_AND :
                         funct == FN_OR  ? ALU_OR  :
                         funct == FN_SLT ? ALU_SLT : ALU_ADD;
            end
            OP_ADDI: begin
                reg_we  = 1'b1;
                wr_idx  = rt;
                use_imm = 1'b1;
            end
            OP_LW: begin
                reg_we     = 1'b1;
                wr_idx     = rt;
                use_imm    = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_SW: begin
                mem_we  = 1'b1;
                use_imm = 1'b1;
            end
            OP_BEQ: alu_op = ALU_SUB;
            default: ;
        endcase
    end

    // next PC: jump, taken branch, or sequential, all modulo 64
    always_comb begin
        pc_next = opcode == OP_J ? instr[5:0] :
                  (opcode == OP_BEQ && zero) ? pc + 6'd1 + imm_ext[5:0] :
                  pc + 6'd1;
    end

    // instruction memory is loadable at any time and deliberately survives reset
    always_ff @(posedge clk) begin
        if (instr_en) imem[mem_adr[5:0]] <= mem_in;
    end

    // architectural state: cleared by reset, frozen while loading, else commits one instruction
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            pc <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
        end else if (!instr_en) begin
            pc <= pc_next;
            if (reg_we && wr_idx != '0) rf[wr_idx] <= wb;
            if (mem_we) dmem[dadr] <= rt_val;
        end
    end

    assign test_mem = dmem[TEST_MEM_ADR];
    assign t1 = rf[REG_T1];
    assign t2 = rf[REG_T2];
    assign t3 = rf[REG_T3];
    assign t4 = rf[REG_T4];
endmodule

// File: tb/tb_shell.sv
// tb_shell: directed tables, hand sequences and random programs against an ISA-level model
module tb_shell;
    logic clk = 1'b0, res = 1'b1, instr_en = 1'b0;
    logic [31:0] mem_adr = '0, mem_in = '0;
    logic signed [31:0] test_mem, t1, t2, t3, t4;
    int total = 0, bad = 0;

    shell dut (
        .clk      (clk),
        .res      (res),
        .instr_en (instr_en),
        .mem_adr  (mem_adr),
        .mem_in   (mem_in),
        .test_mem (test_mem),
        .t1       (t1),
        .t2       (t2),
        .t3       (t3),
        .t4       (t4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          clocks;
        logic [31:0] e1, e2, e3, e4, etm;
    } vec_t;
    vec_t vecs[6];

    logic [31:0] prog [64];
    logic [31:0] m_im [64];
    logic [31:0] m_rf [32];
    logic [31:0] m_dm [64];
    logic [5:0]  m_pc;

    function automatic logic [31:0] enc_r(int s, int t, int d, logic [5:0] fn);
        return {6'h00, 5'(s), 5'(t), 5'(d), 5'h00, fn};
    endfunction
    function automatic logic [31:0] enc_i(logic [5:0] op, int s, int t, int imm);
        return {op, 5'(s), 5'(t), 16'(imm)};
    endfunction
    function automatic logic [31:0] enc_j(int tgt);
        return {6'h02, 26'(tgt)};
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, act, exp);
        end
    endtask

    task automatic chk_all(input string n, input logic [31:0] e1, e2, e3, e4, etm);
        chk({n, ".t1"}, t1, e1);
        chk({n, ".t2"}, t2, e2);
        chk({n, ".t3"}, t3, e3);
        chk({n, ".t4"}, t4, e4);
        chk({n, ".test_mem"}, test_mem, etm);
    endtask

    task automatic m_wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 0) m_rf[r] = v;
    endtask

    // reference: interpret one instruction straight from the ISA rules
    task automatic model_exec();
        logic [31:0] w, a, b, simm;
        logic [5:0] npc, addr;
        w = m_im[m_pc];
        a = m_rf[w[25:21]];
        b = m_rf[w[20:16]];
        simm = {{16{w[15]}}, w[15:0]};
        addr = 6'(a + simm);
        npc = m_pc + 6'd1;
        case (w[31:26])
            6'h00: case (w[5:0])
                6'h20: m_wr(w[15:11], a + b);
                6'h22: m_wr(w[15:11], a - b);
                6'h24: m_wr(w[15:11], a & b);
                6'h25: m_wr(w[15:11], a | b);
                6'h2A: m_wr(w[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                default: ;
            endcase
            6'h08: m_wr(w[20:16], a + simm);
            6'h23: m_wr(w[20:16], m_dm[addr]);
            6'h2B: m_dm[addr] = b;
            6'h04: if (a == b) npc = 6'(int'(m_pc) + 1 + int'($signed(simm)));
            6'h02: npc = w[5:0];
            default: ;
        endcase
        m_pc = npc;
    endtask

    task automatic model_edge();
        if (instr_en) m_im[mem_adr[5:0]] = mem_in;
        if (res) begin
            m_pc = '0;
            for (int i = 0; i < 32; i++) m_rf[i] = '0;
            for (int i = 0; i < 64; i++) m_dm[i] = '0;
        end else if (!instr_en) model_exec();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic load_prog();
        res = 1'b1;
        instr_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            mem_adr = i;
            mem_in = prog[i];
            tick();
        end
        instr_en = 1'b0;
        mem_adr = '0;
        mem_in = '0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = '0;
    endtask

    function automatic int rreg();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(8, 12));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        int k = $urandom_range(0, 13);
        if (k <= 4) return enc_r(rreg(), rreg(), rreg(), fns[$urandom_range(0, 4)]);
        if (k == 5) return enc_i(6'h23, rreg(), rreg(), $urandom_range(0, 20) - 5);
        if (k == 6) return enc_i(6'h2B, rreg(), rreg(), $urandom_range(0, 20) - 5);
        if (k == 7) return enc_i(6'h04, rreg(), rreg(), $urandom_range(0, 8) - 4);
        if (k == 8) return enc_j($urandom_range(0, 63));
        if (k == 9) return ($urandom_range(0, 1) == 1) ? enc_r(rreg(), rreg(), rreg(), 6'h21) : {6'h3F, 26'($urandom)};
        if (k == 10) return '0;
        return enc_i(6'h08, rreg(), rreg(), ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 40)) - 20);
    endfunction

    task automatic load_basic();
        clear_prog();
        prog[0] = enc_i(6'h08, 0, 9, 11);
        prog[1] = enc_i(6'h08, 0, 10, 12);
        prog[2] = enc_i(6'h08, 0, 11, 15);
        prog[3] = enc_r(10, 11, 12, 6'h20);
        prog[4] = enc_i(6'h2B, 9, 12, 0);
        prog[5] = enc_i(6'h23, 9, 10, 0);
        load_prog();
    endtask

    initial begin
        vecs[0] = '{1, 32'd11, 32'd0,  32'd0,  32'd0,  32'd0};
        vecs[1] = '{1, 32'd11, 32'd12, 32'd0,  32'd0,  32'd0};
        vecs[2] = '{1, 32'd11, 32'd12, 32'd15, 32'd0,  32'd0};
        vecs[3] = '{1, 32'd11, 32'd12, 32'd15, 32'd27, 32'd0};
        vecs[4] = '{1, 32'd11, 32'd12, 32'd15, 32'd27, 32'd27};
        vecs[5] = '{1, 32'd11, 32'd27, 32'd15, 32'd27, 32'd27};

        load_basic();
        chk_all("reset", 0, 0, 0, 0, 0);
        res = 1'b0;
        for (int v = 0; v < 6; v++) begin
            repeat (vecs[v].clocks) tick();
            chk_all($sformatf("basic%0d", v), vecs[v].e1, vecs[v].e2, vecs[v].e3, vecs[v].e4, vecs[v].etm);
        end

        res = 1'b1;
        tick();
        res = 1'b0;
        repeat (3) tick();
        chk("midrun.t3", t3, 15);
        res = 1'b1;
        #1;
        chk_all("async_reset", 0, 0, 0, 0, 0);
        tick();
        res = 1'b0;
        repeat (6) tick();
        chk_all("rerun", 11, 27, 15, 27, 27);

        res = 1'b1;
        tick();
        res = 1'b0;
        repeat (3) tick();
        instr_en = 1'b1;
        mem_adr = 63;
        mem_in = '0;
        repeat (3) tick();
        chk_all("frozen", 11, 12, 15, 0, 0);
        instr_en = 1'b0;
        tick();
        chk("resume.t4", t4, 27);
        repeat (2) tick();
        chk_all("resume_end", 11, 27, 15, 27, 27);

        clear_prog();
        prog[0] = enc_i(6'h08, 0, 9, 3);
        prog[1] = enc_i(6'h08, 0, 0, 5);
        prog[2] = enc_r(0, 0, 9, 6'h20);
        load_prog();
        res = 1'b0;
        tick();
        chk("zero_reg.pre", t1, 3);
        repeat (2) tick();
        chk("zero_reg.t1", t1, 0);

        clear_prog();
        prog[0]  = enc_i(6'h08, 0, 9, 1);
        prog[1]  = enc_i(6'h04, 9, 9, 1);
        prog[2]  = enc_i(6'h08, 0, 10, 7);
        prog[3]  = enc_i(6'h08, 0, 11, 3);
        prog[4]  = enc_i(6'h08, 0, 9, -1);
        prog[5]  = enc_i(6'h08, 0, 10, 1);
        prog[6]  = enc_r(9, 10, 11, 6'h2A);
        prog[7]  = enc_r(10, 9, 12, 6'h2A);
        prog[8]  = enc_i(6'h04, 9, 10, 5);
        prog[9]  = enc_i(6'h08, 0, 12, 9);
        prog[10] = enc_j(10);
        load_prog();
        res = 1'b0;
        repeat (3) tick();
        chk("beq_taken.t2", t2, 0);
        chk("beq_taken.t3", t3, 3);
        repeat (4) tick();
        chk_all("slt", 32'hFFFF_FFFF, 1, 1, 0, 0);
        repeat (3) tick();
        chk("beq_not_taken.t4", t4, 9);
        repeat (5) tick();
        chk_all("jump_hold", 32'hFFFF_FFFF, 1, 1, 9, 0);

        clear_prog();
        prog[0] = enc_i(6'h08, 0, 9, -1);
        prog[1] = enc_i(6'h08, 0, 10, 1);
        for (int i = 2; i < 33; i++) prog[i] = enc_r(10, 10, 10, 6'h20);
        prog[33] = enc_i(6'h08, 10, 10, -1);
        prog[34] = enc_i(6'h08, 0, 11, 1);
        prog[35] = enc_r(10, 11, 12, 6'h20);
        prog[36] = enc_r(12, 11, 11, 6'h22);
        load_prog();
        res = 1'b0;
        repeat (36) tick();
        chk_all("overflow_add", 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1, 32'h8000_0000, 0);
        tick();
        chk("overflow_sub.t3", t3, 32'h7FFF_FFFF);

        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 64; i++) prog[i] = rand_instr();
            load_prog();
            res = 1'b0;
            for (int c = 0; c < 150; c++) begin
                instr_en = ($urandom_range(0, 19) == 0);
                mem_adr = $urandom;
                mem_in = rand_instr();
                res = ($urandom_range(0, 99) == 0);
                tick();
                chk_all($sformatf("rand%0d_%0d", p, c), m_rf[9], m_rf[10], m_rf[11], m_rf[12], m_dm[11]);
            end
            instr_en = 1'b0;
            res = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shell.md
SHELL -- requirements
Module: shell

Interface
REQ-001 SHALL have ports: clk  in  1  single rising-edge clock for all state.
REQ-002 SHALL have: res  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: instr_en  in  1  instruction-memory write enable (load mode).
REQ-004 SHALL have: mem_adr  in  32  instruction-memory write word address; only bits [5:0] are used.
REQ-005 SHALL have: mem_in  in  32  instruction word to write.
REQ-006 SHALL have: test_mem  out  32 signed  data memory word 11, combinational.
REQ-007 SHALL have: t1, t2, t3, t4  out  32 signed  register file entries 9, 10, 11, 12, combinational.
REQ-008 SHALL have parameters IMEM_DEPTH, default 64, instruction words; DMEM_DEPTH, default 64, data words.

Function
REQ-009 SHALL be a single-cycle MIPS-subset core; one instruction commits per rising clk when res=0 and instr_en=0.
REQ-010 SHALL write mem_in into imem[mem_adr[5:0]] on a rising clk when instr_en=1, regardless of res.
REQ-011 SHALL hold the PC and all architectural state while instr_en=1.
REQ-012 SHALL use a word-addressed PC; fetch reads imem[PC[5:0]]; sequential next PC is PC+1, wrapping modulo 64.
REQ-013 SHALL execute R-type opcode 0 with funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed); arithmetic is 32-bit wrap-around with no overflow trap.
REQ-014 SHALL execute addi (0x08) with sign-extended imm16, rt as destination.
REQ-015 SHALL execute lw (0x23) and sw (0x2B); the data address is the word index (rs+signext(imm))[5:0], with no byte shift.
REQ-016 SHALL execute beq (0x04) with target PC+1+signext(imm) when rs==rt, and j (0x02) with target instr[5:0].
REQ-017 SHALL hard-wire register 0 to zero; writes to it are discarded.
REQ-018 SHALL treat unknown opcodes, unknown funct codes and the all-zero word as NOP; the PC still advances.
REQ-019 SHALL make lw read the pre-edge memory contents; sw and the register write commit on the same edge.
REQ-020 SHALL use asynchronous reads for the register file and data memory, and synchronous writes.

Reset
REQ-021 SHALL, while res=1, force PC=0, all 32 registers=0 and all data memory words=0, so that test_mem and t1..t4 read 0.
REQ-022 SHALL NOT clear instruction memory on reset; a program loaded during reset survives.
REQ-023 SHALL restart execution at imem[0] on the first rising edge after res deasserts; assertion mid-run aborts immediately.

Structure
REQ-024 SHALL place the opcode and funct constants, the ALU-operation enum and the register indices 9..12 in a shared package mips_pkg.
REQ-025 SHALL instantiate one sub-module, mips_alu (a, b, op -> result, zero); the register file, memories, control and PC stay in shell.

Verification
REQ-026 Load the sequence: addi $9,$0,11; addi $10,$0,12; addi $11,$0,15; add $12,$10,$11; sw $12,0($9); lw $10,0($9). Load it at addresses 0..5 with res=1, then release res. After 6 clocks the required outputs are t1=11, t2=27, t3=15, t4=27, test_mem=27; after 4 clocks t2=12.
REQ-027 Assert res mid-program -> t1..t4 and test_mem read 0 immediately; after release the program re-runs to the same final values.
REQ-028 Run addi $0,$0,5 then add $9,$0,$0 -> t1=0.
REQ-029 Run addi $9,$0,1; beq $9,$9,+1; addi $10,$0,7; addi $11,$0,3 -> t2=0, t3=3; slt with $9=-1 and $10=1 -> 1.
REQ-030 Raise instr_en for 3 clocks mid-run -> the PC and outputs stay frozen, then resume with no lost instruction.
REQ-031 Run addi $9,$0,-1 followed by add overflow 0x7FFFFFFF+1 -> t1=-1, result 0x80000000, no exception.
